// File: rtl/mem_access_unit.sv
// Memory-access stage: one data-bus transaction per instruction, big-endian store lane
// alignment and load extract/extend/merge (LWL/LWR). LL/SC link bit enabled by `MEM_LLSC_EN`.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_instr_op,
  input  logic [31:0] i_mem_addr,
  input  logic [1:0]  i_byte_off,
  input  logic [3:0]  i_mem_sel,
  input  logic        i_bad_addr,
  input  logic [31:0] i_rt_value,
  input  logic [4:0]  i_dest_reg,
  input  logic        i_flush,
  input  logic        i_llbit_clr,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_done,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_reg,
  output logic [31:0] o_wb_data,
  output logic        o_exc_valid,
  output logic [4:0]  o_exc_code,
  output logic [31:0] o_badvaddr
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_LL};
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_SC};
  endfunction

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rt_q;
  logic [4:0]  dest_q;
  logic        flush_q;
  logic        wb_we_q;
  logic        exc_q;
  logic        sc_fail;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_mask;

`ifdef MEM_LLSC_EN
  logic llbit;

  // A clear request on the same edge as an LL completion wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit <= 1'b0;
    end else if (i_llbit_clr) begin
      llbit <= 1'b0;
    end else if (state == BUS && i_bus_ack && op_q == OP_LL) begin
      llbit <= 1'b1;
    end else if (state == BUS && i_bus_ack && op_q == OP_SC) begin
      llbit <= 1'b0;
    end
  end

  assign sc_fail = (i_instr_op == OP_SC) && !llbit;
`else
  logic unused_llbit_clr;
  assign unused_llbit_clr = i_llbit_clr;
  assign sc_fail = 1'b0;
`endif

  always_comb begin
    store_data = i_rt_value;
    case (i_instr_op)
      OP_SB:   store_data = {4{i_rt_value[7:0]}};
      OP_SH:   store_data = {2{i_rt_value[15:0]}};
      OP_SWL:  store_data = i_rt_value >> {i_byte_off, 3'b000};
      OP_SWR:  store_data = i_rt_value << {~i_byte_off, 3'b000};
      default: store_data = i_rt_value;
    endcase
  end

  // Byte k sits at rdata[31-8k -: 8]; shifting right by 8(3-k) brings it to [7:0].
  assign rd_shift = i_bus_rdata >> {~off_q, 3'b000};
  assign rd_half  = off_q[1] ? i_bus_rdata[15:0] : i_bus_rdata[31:16];
  assign lwl_mask = ~(32'hFFFF_FFFF << {off_q, 3'b000});
  assign lwr_mask = (off_q == 2'd3) ? 32'd0 : (32'hFFFF_FFFF << ({off_q, 3'b000} + 5'd8));

  always_comb begin
    load_data = i_bus_rdata;
    case (op_q)
      OP_LB:   load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_data = {24'd0, rd_shift[7:0]};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      OP_LWL:  load_data = (i_bus_rdata << {off_q, 3'b000}) | (rt_q & lwl_mask);
      OP_LWR:  load_data = (rt_q & lwr_mask) | (i_bus_rdata >> {~off_q, 3'b000});
      default: load_data = i_bus_rdata;
    endcase
  end

  // Handshakes: an instruction is taken on the edge where i_valid & o_ready; the bus
  // request then stays high with addr/sel/we/wdata frozen until the edge that samples
  // i_bus_ack, and i_bus_rdata is used only on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      o_ready     <= 1'b1;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'd0;
      o_bus_sel   <= 4'd0;
      o_bus_wdata <= 32'd0;
      o_done      <= 1'b0;
      o_wb_reg    <= 5'd0;
      o_wb_data   <= 32'd0;
      o_exc_code  <= 5'd0;
      o_badvaddr  <= 32'd0;
      op_q        <= 6'd0;
      off_q       <= 2'd0;
      rt_q        <= 32'd0;
      dest_q      <= 5'd0;
      flush_q     <= 1'b0;
      wb_we_q     <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      wb_we_q <= 1'b0;
      exc_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid && o_ready && (is_load_op(i_instr_op) || is_store_op(i_instr_op))) begin
            op_q    <= i_instr_op;
            off_q   <= i_byte_off;
            rt_q    <= i_rt_value;
            dest_q  <= i_dest_reg;
            flush_q <= 1'b0;
            o_ready <= 1'b0;
            if (i_bad_addr) begin
              state      <= DONE;
              o_done     <= 1'b1;
              exc_q      <= 1'b1;
              o_exc_code <= is_load_op(i_instr_op) ? 5'd4 : 5'd5;
              o_badvaddr <= {i_mem_addr[31:2], i_byte_off};
            end else if (sc_fail) begin
              state     <= DONE;
              o_done    <= 1'b1;
              wb_we_q   <= 1'b1;
              o_wb_reg  <= i_dest_reg;
              o_wb_data <= 32'd0;
            end else begin
              state       <= BUS;
              o_bus_req   <= 1'b1;
              o_bus_we    <= is_store_op(i_instr_op);
              o_bus_addr  <= i_mem_addr;
              o_bus_sel   <= i_mem_sel;
              o_bus_wdata <= store_data;
            end
          end
        end
        BUS: begin
          flush_q <= flush_q | i_flush;
          if (i_bus_ack) begin
            state     <= DONE;
            o_bus_req <= 1'b0;
            o_bus_we  <= 1'b0;
            o_done    <= 1'b1;
            if (is_load_op(op_q) || op_q == OP_SC) begin
              wb_we_q   <= ~(flush_q | i_flush);
              o_wb_reg  <= dest_q;
              o_wb_data <= is_load_op(op_q) ? load_data : 32'd1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // A flush landing in the completion cycle itself still squashes the pulse.
  assign o_wb_we     = wb_we_q & ~i_flush;
  assign o_exc_valid = exc_q & ~i_flush;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the pipeline, directly downstream of the ID-stage address processor. It accepts one memory instruction at a time with its word-aligned address, byte-lane select and misalignment flag. It runs a single request/acknowledge transaction on the data bus, aligns store data onto big-endian byte lanes, and extracts, extends or merges load data, including LWL/LWR. It produces one writeback or exception pulse per instruction.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; everything on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `i_valid`  in  1  instruction offered
- `o_ready`  out  1  unit can accept (state IDLE)
- `i_instr_op`  in  6  opcode (`OP_*` values)
- `i_mem_addr`  in  32  word-aligned address
- `i_byte_off`  in  2  low address bits [1:0]
- `i_mem_sel`  in  4  byte-lane select; bit 3 = lane [31:24]
- `i_bad_addr`  in  1  misaligned access
- `i_rt_value`  in  32  store source / LWL-LWR merge base
- `i_dest_reg`  in  5  load destination register
- `i_flush`  in  1  squash the in-flight instruction's writeback
- `i_llbit_clr`  in  1  clear LLbit (ERET/exception)
- `o_bus_req`, `o_bus_we`  out  1  bus request / write
- `o_bus_addr`  out  32  bus address
- `o_bus_sel`  out  4  bus byte strobes
- `o_bus_wdata`  out  32  bus write data
- `i_bus_ack`  in  1  transfer done; `i_bus_rdata` valid this cycle
- `i_bus_rdata`  in  32  read data
- `o_done`  out  1  one-cycle completion pulse
- `o_wb_we`, `o_wb_reg`, `o_wb_data`  out  1/5/32  register writeback
- `o_exc_valid`  out  1  exception pulse
- `o_exc_code`  out  5  4 = AdEL, 5 = AdES
- `o_badvaddr`  out  32  `{i_mem_addr[31:2], i_byte_off}`

## Operation
- **FSM states:** IDLE, BUS, DONE.
  - IDLE→BUS: accept of a memory op without `i_bad_addr`.
  - IDLE→DONE: accept with `i_bad_addr`, or SC with LLbit clear.
  - BUS→DONE: on `i_bus_ack`.
  - DONE→IDLE: unconditional.
- **Accept:** `i_valid & o_ready`. All inputs are latched at accept.
- **Non-memory opcodes:** `i_valid` is ignored and the unit stays in IDLE.
- **Bus request:** in BUS, `o_bus_req`=1 and `addr`/`sel`/`we`/`wdata` are held stable until ack. `o_bus_sel` = latched `i_mem_sel`.
- **Store lanes:**
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW, SC: rt.
  - SWL: rt >> 8·off.
  - SWR: rt << 8·(3−off).
- **Load extraction** (k = byte offset):
  - LB/LBU: `rdata[31−8k −: 8]`, sign-extended / zero-extended.
  - LH/LHU: `rdata[31:16]` for k=0, `rdata[15:0]` for k=2, sign-/zero-extended.
  - LW, LL: rdata.
  - LWL: `(rdata << 8k) | (rt & (2^(8k)−1))`.
  - LWR: `(rt & ~(2^(8(k+1))−1)) | (rdata >> 8(3−k))`. The mask is treated as 0 when k=3.
- **Exceptions:** a bad address raises AdEL for loads and AdES for stores. No bus access occurs and `o_wb_we`=0.
- **Flush:** `i_flush` seen in any non-IDLE cycle suppresses `o_wb_we` and `o_exc_valid` for that instruction. A BUS transaction still completes (it is never aborted). `o_done` still pulses.

## Timing
- **Reset values:** all outputs 0, state IDLE, LLbit 0, and `o_ready`=1 the cycle after reset. Reset during BUS drops `o_bus_req` at the next edge; a late ack is ignored.
- **Latency:**
  - Accept at edge N → `o_bus_req` high from N+1.
  - Ack sampled at edge M → `o_done`/writeback valid for exactly one cycle after M.
  - Minimum accept-to-done is 2 cycles.
  - Bad-address and failed-SC cases: done at N+1.
- **Throughput:** `o_ready`=0 in BUS and DONE, so at most one instruction every 3 cycles with zero-wait ack.
- **LLbit priority:** `i_llbit_clr` and an LL completion on the same edge → clear wins.
- **Data hold:** `o_wb_data`/`o_wb_reg` hold their last value outside DONE. `o_wb_we` and `o_exc_valid` are 0 outside DONE.

## Configuration
- **`MEM_LLSC_EN` defined:**
  - LL behaves as LW and sets LLbit on completion.
  - SC with LLbit=1 performs SW, writes 1 to rt and clears LLbit.
  - SC with LLbit=0 does no bus access and writes 0 to rt.
- **Undefined:** no LLbit register. LL behaves as LW; SC is an unconditional SW that writes 1 to rt. `i_llbit_clr` is ignored.

## Test plan
- LB, addr 0x1003 (sel 0001), rdata 0x123456F0, ack same cycle → `o_wb_data`=0xFFFFFFF0, `o_done` 2 cycles after accept.
- LWL, off 1, rt 0xAABBCCDD, rdata 0x11223344 → 0x223344DD. LWR, off 1, same values → 0xAABB1122.
- SWR, off 0, rt 0x11223344 → `o_bus_sel`=1000, `o_bus_wdata`=0x44000000, req held over 3 wait cycles until ack, no writeback.
- SH with `i_bad_addr`=1, addr 0x2000, off 1 → no `o_bus_req`, `o_exc_valid`=1, code 5, `o_badvaddr`=0x2001.
- With `MEM_LLSC_EN`: LL, then SC → SC writes 1 to rt. LL, then `i_llbit_clr`, then SC → no bus access, rt written 0.
- `rst` asserted mid-BUS with ack arriving one cycle later → req low after the reset edge, no `o_done`, `o_ready`=1.
